// File: rtl/bar_capture_pkg.sv
// Shared definitions for the bar_capture serial capture engine:
// FSM state codes, host register offsets and capture RAM geometry.
package bar_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int unsigned CAP_DEPTH  = 64;
  localparam int unsigned CAP_BYTE_W = 8;
  localparam int unsigned REG_STATUS = 'h0;
  localparam int unsigned REG_ARM    = 'h10;
  localparam int unsigned REG_DIV    = 'h11;
  localparam int unsigned RAM_BASE   = 'h100;

endpackage

// File: rtl/bar_capture_tick.sv
// Input synchronizer and bit-rate divider; divisor is latched only when the
// capture is armed so host writes mid-capture do not disturb pacing.
module bar_capture_tick (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sig,
  input  logic       i_load,
  input  logic [7:0] i_div,
  output logic       o_demo_s,
  output logic       o_tick
);

  logic [1:0] r_sync;
  logic [7:0] r_div_sh;
  logic [7:0] r_div_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= '0;
      r_div_sh  <= '0;
      r_div_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], i_sig};
      if (i_load) begin
        r_div_sh  <= i_div;
        r_div_cnt <= '0;
      end else if (o_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
    end
  end

  assign o_demo_s = r_sync[1];
  assign o_tick   = (r_div_cnt == r_div_sh);

endmodule

// File: rtl/bar_capture.sv
// Serial capture engine: start-bit qualified, MSB-first deserializer that
// fills a 64-byte host-readable RAM, controlled through host registers.
module bar_capture
  import bar_capture_pkg::*;
#(
  parameter int AW = 24,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          demo_sig,
  output logic          cap_busy,
  output logic          cap_done_stb,
  input  logic [AW-1:0] i_gb_addr,
  input  logic [DW-1:0] i_gb_wdata,
  input  logic          i_gb_we,
  output logic [DW-1:0] o_gb_rdata
);

`ifndef GHOSTBUS_bar_capture
`define GHOSTBUS_bar_capture
`endif
  `GHOSTBUS_bar_capture

  cap_state_t r_state;
  logic       r_arm, r_arm_q;
  logic [7:0] r_div;
  logic [6:0] r_count;
  logic [5:0] r_wptr;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic       r_wr_pend;
  logic       r_done_stb;
  logic [CAP_BYTE_W-1:0] r_ram [CAP_DEPTH];

  logic w_arm_rise, w_load, w_demo_s, w_tick, w_ram_we;
  logic w_sel_status, w_sel_arm, w_sel_div, w_sel_ram;
  logic w_unused;

  assign w_arm_rise = r_arm & ~r_arm_q;
  assign w_load     = (r_state == ST_IDLE) & w_arm_rise;
  // A completed byte is committed one cycle after its last bit, unless aborted.
  assign w_ram_we   = (r_state == ST_CAPTURE) & r_arm & r_wr_pend;

  assign w_sel_status = (i_gb_addr == AW'(REG_STATUS));
  assign w_sel_arm    = (i_gb_addr == AW'(REG_ARM));
  assign w_sel_div    = (i_gb_addr == AW'(REG_DIV));
  assign w_sel_ram    = (i_gb_addr[AW-1:6] == (AW-6)'(RAM_BASE >> 6));
  assign w_unused     = ^i_gb_wdata[DW-1:8];

  bar_capture_tick u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_sig    (demo_sig),
    .i_load   (w_load),
    .i_div    (r_div),
    .o_demo_s (w_demo_s),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm   <= 1'b0;
      r_arm_q <= 1'b0;
      r_div   <= '0;
    end else begin
      r_arm_q <= r_arm;
      if (i_gb_we && w_sel_arm) r_arm <= i_gb_wdata[0];
      if (i_gb_we && w_sel_div) r_div <= i_gb_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_wptr     <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_wr_pend  <= 1'b0;
      r_done_stb <= 1'b0;
    end else begin
      r_wr_pend  <= 1'b0;
      r_done_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arm_rise) begin
            r_state   <= ST_ARMED;
            r_count   <= '0;
            r_wptr    <= '0;
            r_bit_cnt <= '0;
          end
        end
        ST_ARMED: begin
          if (!r_arm) begin
            r_state <= ST_IDLE;
          end else if (w_tick && w_demo_s) begin
            r_state   <= ST_CAPTURE;
            r_bit_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          if (!r_arm) begin
            r_state <= ST_IDLE;
          end else begin
            if (r_wr_pend) begin
              r_wptr  <= r_wptr + 6'd1;
              r_count <= r_count + 7'd1;
              if (r_count == 7'(CAP_DEPTH - 1)) begin
                r_state    <= ST_DONE;
                r_done_stb <= 1'b1;
              end
            end
            if (w_tick) begin
              r_shreg   <= {r_shreg[6:0], w_demo_s};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_wr_pend <= (r_bit_cnt == 3'd7);
            end
          end
        end
        ST_DONE: begin
          if (!r_arm) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture RAM is deliberately not reset so bytes survive an abort or reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[r_wptr] <= r_shreg;
  end

  always_comb begin
    o_gb_rdata = '0;
    if (w_sel_status) begin
      o_gb_rdata[6:0] = r_count;
      o_gb_rdata[9:8] = r_state;
    end else if (w_sel_arm) begin
      o_gb_rdata[0] = r_arm;
    end else if (w_sel_div) begin
      o_gb_rdata[7:0] = r_div;
    end else if (w_sel_ram) begin
      o_gb_rdata[7:0] = r_ram[i_gb_addr[5:0]];
    end
  end

  assign cap_busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign cap_done_stb = r_done_stb;

endmodule
